// File: rtl/inst_fetch.sv
// Instruction fetch unit: assembles 32-bit little-endian instructions from a
// byte-wide request/grant memory port and presents them to the IF/ID register.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    input  logic        mem_gnt,
    input  logic [7:0]  mem_din,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic        get_inst,
    output logic [31:0] if_pc,
    output logic [31:0] if_inst
);

    typedef enum logic {FETCH, HOLD} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [2:0]  issue_cnt, issue_nxt;
    logic [2:0]  recv_cnt, recv_nxt;
    logic        pend, pend_nxt;
    logic [31:0] inst_buf, buf_nxt;
    logic        get_nxt;
    logic [31:0] if_pc_nxt, if_inst_nxt;
    logic        req_int;
    logic        deliver;
    logic [31:0] word;
    logic [31:0] target_aligned;

    assign target_aligned = branch_target_i & 32'hFFFF_FFFC;

    // Reset only gates the port output; the flops are already held in reset.
    assign mem_req = req_int & ~rst;

    always_comb begin
        state_nxt   = state;
        pc_nxt      = pc;
        issue_nxt   = issue_cnt;
        recv_nxt    = recv_cnt;
        pend_nxt    = 1'b0;
        buf_nxt     = inst_buf;
        get_nxt     = 1'b0;
        if_pc_nxt   = if_pc;
        if_inst_nxt = if_inst;
        req_int     = 1'b0;
        mem_addr    = pc + {29'd0, issue_cnt};
        deliver     = 1'b0;
        word        = inst_buf;

        case (state)
            FETCH: begin
                req_int = (issue_cnt < 3'd4) & ~branch_i;
                if (req_int && mem_gnt) begin
                    issue_nxt = issue_cnt + 3'd1;
                    pend_nxt  = 1'b1;
                end
                if (pend) begin
                    buf_nxt[{recv_cnt[1:0], 3'b000} +: 8] = mem_din;
                    recv_nxt = recv_cnt + 3'd1;
                    if (recv_cnt == 3'd3) begin
                        word = {mem_din, inst_buf[23:0]};
                        if (stall_i) begin
                            state_nxt = HOLD;
                        end else begin
                            deliver = 1'b1;
                        end
                    end
                end
            end
            HOLD: begin
                if (!stall_i) begin
                    deliver = 1'b1;
                end
            end
            default: state_nxt = FETCH;
        endcase

        if (deliver) begin
            get_nxt     = 1'b1;
            if_pc_nxt   = pc;
            if_inst_nxt = word;
            pc_nxt      = pc + 32'd4;
            issue_nxt   = 3'd0;
            recv_nxt    = 3'd0;
            state_nxt   = FETCH;
        end

        // A redirect wins over everything, including a same-cycle completion.
        if (branch_i) begin
            pc_nxt      = target_aligned;
            issue_nxt   = 3'd0;
            recv_nxt    = 3'd0;
            pend_nxt    = 1'b0;
            buf_nxt     = 32'd0;
            state_nxt   = FETCH;
            get_nxt     = 1'b0;
            if_pc_nxt   = if_pc;
            if_inst_nxt = if_inst;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            issue_cnt <= 3'd0;
            recv_cnt  <= 3'd0;
            pend      <= 1'b0;
            inst_buf  <= 32'd0;
            get_inst  <= 1'b0;
            if_pc     <= 32'd0;
            if_inst   <= 32'd0;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            issue_cnt <= issue_nxt;
            recv_cnt  <= recv_nxt;
            pend      <= pend_nxt;
            inst_buf  <= buf_nxt;
            get_inst  <= get_nxt;
            if_pc     <= if_pc_nxt;
            if_inst   <= if_inst_nxt;
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed scenarios plus random traffic, checked every
// cycle against a transaction-level model built from byte queues.
module tb_inst_fetch;

    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall_i = 1'b0;
    logic        branch_i = 1'b0;
    logic [31:0] branch_target_i = 32'd0;
    logic        mem_gnt = 1'b0;
    logic [7:0]  mem_din = 8'd0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        get_inst;
    logic [31:0] if_pc;
    logic [31:0] if_inst;

    always #5 clk = ~clk;

    inst_fetch #(.RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .branch_i(branch_i),
        .branch_target_i(branch_target_i), .mem_gnt(mem_gnt), .mem_din(mem_din),
        .mem_req(mem_req), .mem_addr(mem_addr), .get_inst(get_inst),
        .if_pc(if_pc), .if_inst(if_inst)
    );

    logic [7:0] mem [0:1023];
    int total = 0;
    int bad = 0;
    int cyc = 0;

    // environment: memory answers the cycle after a granted request
    logic        env_pend = 1'b0;
    logic [31:0] env_addr = 32'd0;

    // reference model
    logic [31:0] m_pc;
    int          m_gr;
    logic [7:0]  m_bytes[$];
    logic        m_infl, m_hold, m_gi;
    logic [31:0] m_word, m_ipc, m_iinst;

    logic        h_req  [0:4095];
    logic [31:0] h_addr [0:4095];
    logic        h_gi   [0:4095];
    logic [31:0] h_pc   [0:4095];
    logic [31:0] h_inst [0:4095];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mword(input logic [31:0] a);
        logic [31:0] a0, a1, a2, a3;
        a0 = a; a1 = a + 32'd1; a2 = a + 32'd2; a3 = a + 32'd3;
        return {mem[a3[9:0]], mem[a2[9:0]], mem[a1[9:0]], mem[a0[9:0]]};
    endfunction

    task automatic m_deliver(input logic [31:0] w);
        m_gi = 1'b1; m_ipc = m_pc; m_iinst = w;
        m_pc = m_pc + 32'd4; m_gr = 0; m_bytes.delete(); m_hold = 1'b0;
    endtask

    task automatic release_reset();
        rst = 1'b0;
        m_pc = RPC; m_gr = 0; m_bytes.delete(); m_infl = 1'b0; m_hold = 1'b0;
        m_gi = 1'b0; m_ipc = 32'd0; m_iinst = 32'd0; m_word = 32'd0;
        env_pend = 1'b0; cyc = 0;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        mem_din = 8'($urandom);
        @(posedge clk); #1;
        release_reset();
    endtask

    task automatic run_cycle(input bit s, input bit b, input bit g, input logic [31:0] t);
        logic        e_req;
        logic [31:0] e_addr, a;
        stall_i = s; branch_i = b; mem_gnt = g; branch_target_i = t;
        mem_din = env_pend ? mem[env_addr[9:0]] : 8'($urandom);
        #1;
        e_req  = !m_hold && (m_gr < 4) && !b;
        e_addr = m_pc + 32'(m_gr);
        chk("mem_req", {31'd0, mem_req}, {31'd0, e_req});
        if (e_req) chk("mem_addr", mem_addr, e_addr);
        chk("get_inst", {31'd0, get_inst}, {31'd0, m_gi});
        chk("if_pc", if_pc, m_ipc);
        chk("if_inst", if_inst, m_iinst);
        if (cyc < 4096) begin
            h_req[cyc] = mem_req; h_addr[cyc] = mem_addr; h_gi[cyc] = get_inst;
            h_pc[cyc] = if_pc; h_inst[cyc] = if_inst;
        end
        env_pend = mem_req && g;
        env_addr = mem_addr;
        m_gi = 1'b0;
        if (b) begin
            m_pc = t & 32'hFFFF_FFFC; m_gr = 0; m_bytes.delete();
            m_infl = 1'b0; m_hold = 1'b0;
        end else if (m_hold) begin
            if (!s) m_deliver(m_word);
        end else begin
            if (m_infl) begin
                a = m_pc + 32'(m_bytes.size());
                m_bytes.push_back(mem[a[9:0]]);
            end
            m_infl = e_req && g;
            if (m_infl) m_gr++;
            if (m_bytes.size() == 4) begin
                m_word = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
                if (s) m_hold = 1'b1;
                else   m_deliver(m_word);
            end
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h10; mem[3] = 8'h00;

        // reset state
        #1;
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_get", {31'd0, get_inst}, 32'd0);
        chk("rst_pc", if_pc, 32'd0);
        chk("rst_inst", if_inst, 32'd0);
        @(posedge clk); #1;
        release_reset();

        // back-to-back fetch, grant always 1
        for (int i = 0; i < 12; i++) run_cycle(0, 0, 1, 0);
        for (int i = 0; i < 4; i++) chk("t1_addr", h_addr[i], 32'(i));
        chk("t1_gi4", {31'd0, h_gi[4]}, 32'd0);
        chk("t1_gi5", {31'd0, h_gi[5]}, 32'd1);
        chk("t1_pc5", h_pc[5], 32'd0);
        chk("t1_inst5", h_inst[5], 32'h0010_0513);
        chk("t1_gi10", {31'd0, h_gi[10]}, 32'd1);
        chk("t1_pc10", h_pc[10], 32'd4);

        // grant withheld in cycles 1-2
        reset_dut();
        for (int i = 0; i < 9; i++) run_cycle(0, 0, !(i == 1 || i == 2), 0);
        for (int i = 1; i < 4; i++) chk("t2_addr_hold", h_addr[i], 32'd1);
        chk("t2_gi6", {31'd0, h_gi[6]}, 32'd0);
        chk("t2_gi7", {31'd0, h_gi[7]}, 32'd1);
        chk("t2_inst7", h_inst[7], 32'h0010_0513);

        // stall in cycles 4-7
        reset_dut();
        for (int i = 0; i < 11; i++) run_cycle(i >= 4 && i <= 7, 0, 1, 0);
        for (int i = 5; i < 9; i++) begin
            chk("t3_req_hold", {31'd0, h_req[i]}, 32'd0);
            chk("t3_gi_hold", {31'd0, h_gi[i]}, 32'd0);
        end
        chk("t3_gi9", {31'd0, h_gi[9]}, 32'd1);
        chk("t3_pc9", h_pc[9], 32'd0);
        chk("t3_addr9", h_addr[9], 32'd4);

        // branch in cycle 2 to 0x103
        reset_dut();
        for (int i = 0; i < 10; i++) run_cycle(0, i == 2, 1, 32'h103);
        chk("t4_req2", {31'd0, h_req[2]}, 32'd0);
        chk("t4_addr3", h_addr[3], 32'h100);
        chk("t4_gi8", {31'd0, h_gi[8]}, 32'd1);
        chk("t4_pc8", h_pc[8], 32'h100);
        chk("t4_inst8", h_inst[8], mword(32'h100));

        // branch in the cycle byte 3 arrives
        reset_dut();
        for (int i = 0; i < 12; i++) run_cycle(0, i == 4, 1, 32'h40);
        for (int i = 5; i < 10; i++) chk("t5_no_gi", {31'd0, h_gi[i]}, 32'd0);
        chk("t5_addr5", h_addr[5], 32'h40);
        chk("t5_gi10", {31'd0, h_gi[10]}, 32'd1);
        chk("t5_pc10", h_pc[10], 32'h40);

        // branch while holding
        reset_dut();
        for (int i = 0; i < 14; i++) run_cycle(i >= 4 && i <= 9, i == 6, 1, 32'h81);
        for (int i = 5; i < 12; i++) chk("t6_no_gi", {31'd0, h_gi[i]}, 32'd0);
        chk("t6_addr7", h_addr[7], 32'h80);
        chk("t6_gi12", {31'd0, h_gi[12]}, 32'd1);
        chk("t6_pc12", h_pc[12], 32'h80);

        // asynchronous reset between edges, after one delivery
        reset_dut();
        for (int i = 0; i < 7; i++) run_cycle(0, 0, 1, 0);
        stall_i = 1'b0; branch_i = 1'b0; mem_gnt = 1'b1;
        #2 rst = 1'b1;
        #1;
        chk("t7_req", {31'd0, mem_req}, 32'd0);
        chk("t7_get", {31'd0, get_inst}, 32'd0);
        chk("t7_pc", if_pc, 32'd0);
        chk("t7_inst", if_inst, 32'd0);
        @(posedge clk); #1;
        release_reset();
        for (int i = 0; i < 8; i++) run_cycle(0, 0, 1, 0);
        chk("t7_addr0", h_addr[0], RPC);
        chk("t7_gi5", {31'd0, h_gi[5]}, 32'd1);
        chk("t7_inst5", h_inst[5], 32'h0010_0513);

        // random traffic
        reset_dut();
        for (int i = 0; i < 3000; i++)
            run_cycle($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
                      $urandom_range(0, 9) < 7, $urandom);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
